// File: rtl/memoria_pkg.sv
// Shared types and lane helpers for the memoria_dados data memory.
package memoria_pkg;

   localparam int DEPTH_WORDS_DEF = 256;
   localparam int LATENCY_DEF     = 2;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      BYTE   = 2'b00,
      HALF   = 2'b01,
      WORD   = 2'b10,
      DOUBLE = 2'b11
   } size_t;

   function automatic logic misaligned(size_t size, logic [2:0] off);
      case (size)
         BYTE:    misaligned = 1'b0;
         HALF:    misaligned = off[0];
         WORD:    misaligned = |off[1:0];
         default: misaligned = |off;
      endcase
   endfunction

   // Bit mask of the byte lanes touched by an access, already shifted into place.
   function automatic logic [63:0] lane_mask(size_t size, logic [2:0] off);
      logic [63:0] base;
      case (size)
         BYTE:    base = 64'h0000_0000_0000_00ff;
         HALF:    base = 64'h0000_0000_0000_ffff;
         WORD:    base = 64'h0000_0000_ffff_ffff;
         default: base = 64'hffff_ffff_ffff_ffff;
      endcase
      lane_mask = base << {off, 3'b000};
   endfunction

endpackage

// File: rtl/memoria_dados_if.sv
// Processor-side request/response bus of the data memory.
interface memoria_dados_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/extensor_carga.sv
// Load lane extraction: pulls the addressed lanes down to bit 0 and extends them.
module extensor_carga
   import memoria_pkg::*;
(
   input  logic [63:0] word,
   input  logic [2:0]  addr,
   input  size_t       size,
   input  logic        load_unsigned,
   output logic [63:0] result
);

   logic [63:0] lanes;

   assign lanes = word >> {addr, 3'b000};

   always_comb begin
      result = lanes;
      case (size)
         BYTE:    result = {{56{~load_unsigned & lanes[7]}},  lanes[7:0]};
         HALF:    result = {{48{~load_unsigned & lanes[15]}}, lanes[15:0]};
         WORD:    result = {{32{~load_unsigned & lanes[31]}}, lanes[31:0]};
         default: result = lanes;
      endcase
   end

endmodule

// File: rtl/memoria_dados.sv
// Fixed-latency 64-bit data memory with byte/half/word/double loads and stores.
//  state | meaning
//  IDLE  | ready for a request
//  WAIT  | access latency countdown; access executes when the counter is 0
//  RESP  | response held until resp_ready
module memoria_dados
   import memoria_pkg::*;
#(
   parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
   parameter int LATENCY     = LATENCY_DEF
) (
   input  logic           clk,
   input  logic           reset,
   memoria_dados_if.slave bus,
   output logic [1:0]     stateOut
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               we_q, we_d;
   size_t              size_q, size_d;
   logic               uns_q, uns_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [2:0]         off_q, off_d;
   logic [63:0]        wdata_q, wdata_d;
   logic               resp_valid_q, resp_valid_d;
   logic               resp_err_q, resp_err_d;
   logic [63:0]        resp_rdata_q, resp_rdata_d;

   logic [63:0]        mem_q [DEPTH_WORDS];

   logic [63:0] word_rd, load_data, mask, wr_word;
   logic        req_err, commit, mem_we;

   assign word_rd = mem_q[idx_q];
   assign mask    = lane_mask(size_q, off_q);
   assign wr_word = (word_rd & ~mask) | ((wdata_q << {off_q, 3'b000}) & mask);
   assign req_err = misaligned(size_t'(bus.req_size), bus.req_addr[2:0])
                    || (bus.req_addr[63:3] >= 61'(DEPTH_WORDS));
   assign commit  = (state_q == WAIT) && (cnt_q == 4'd0);
   assign mem_we  = commit && we_q;

   extensor_carga u_ext (
      .word          (word_rd),
      .addr          (off_q),
      .size          (size_q),
      .load_unsigned (uns_q),
      .result        (load_data)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      size_d       = size_q;
      uns_d        = uns_q;
      idx_d        = idx_q;
      off_d        = off_q;
      wdata_d      = wdata_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               size_d  = size_t'(bus.req_size);
               uns_d   = bus.req_unsigned;
               idx_d   = bus.req_addr[IDX_W+2:3];
               off_d   = bus.req_addr[2:0];
               wdata_d = bus.req_wdata;
               if (req_err) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = we_q ? 64'd0 : load_data;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         size_q       <= BYTE;
         uns_q        <= 1'b0;
         idx_q        <= '0;
         off_q        <= '0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         idx_q        <= idx_d;
         off_q        <= off_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // Array is deliberately not reset; the write is gated by state so a reset in WAIT drops it.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[idx_q] <= wr_word;
   end

   assign stateOut       = state_q;
   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_memoria_dados.sv
// Randomized bench for memoria_dados against a byte-array reference model.
module tb_memoria_dados;
   import memoria_pkg::*;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] state_out;

   always #5 clk = ~clk;

   memoria_dados_if bus();

   memoria_dados #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .stateOut (state_out)
   );

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] mem_m [DEPTH*8];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model_load(input logic [63:0] a, input logic [1:0] sz, input logic uns);
      int          n;
      logic [63:0] v;
      n = 1 << sz;
      v = '0;
      for (int i = n - 1; i >= 0; i--) v = (v << 8) | 64'(mem_m[int'(a) + i]);
      if (!uns && n < 8 && v[8*n-1]) v = v | ({64{1'b1}} << (8*n));
      return v;
   endfunction

   task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input int hold, output logic [63:0] rd);
      int          n;
      int          edges;
      logic        exp_err;
      logic [63:0] exp_rd;
      n       = 1 << sz;
      exp_err = ((addr % 64'(n)) != 64'd0) || ((addr >> 3) >= 64'(DEPTH));
      exp_rd  = (we || exp_err) ? 64'd0 : model_load(addr, sz, uns);
      @(negedge clk);
      check("ready_idle", 64'(bus.req_ready), 64'd1);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.resp_ready   = 1'b0;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("state_acc", 64'(state_out), exp_err ? 64'd2 : 64'd1);
      edges = 1;
      while (!bus.resp_valid && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      check("latency", 64'(edges), exp_err ? 64'd1 : 64'(LAT + 1));
      check("rdata", bus.resp_rdata, exp_rd);
      check("err", 64'(bus.resp_err), 64'(exp_err));
      for (int i = 0; i < hold; i++) begin
         bus.req_valid = 1'($urandom_range(0, 1));
         bus.req_we    = 1'b1;
         bus.req_size  = 2'd3;
         bus.req_addr  = 64'($urandom_range(0, DEPTH - 1)) << 3;
         bus.req_wdata = {$urandom, $urandom};
         @(posedge clk); #1;
         check("hold_valid", 64'(bus.resp_valid), 64'd1);
         check("hold_rdata", bus.resp_rdata, exp_rd);
         check("hold_err", 64'(bus.resp_err), 64'(exp_err));
         check("hold_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      rd = bus.resp_rdata;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      check("resp_done", 64'({bus.resp_valid, state_out}), 64'd0);
      if (we && !exp_err)
         for (int i = 0; i < n; i++) mem_m[int'(addr) + i] = wdata[8*i +: 8];
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [63:0] rd;
      logic [63:0] addr;
      logic [63:0] exp_st;
      logic [1:0]  sz;
      int          ph;
      int          hold;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      bus.resp_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", 64'(state_out), 64'd0);
      check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("rst_resp_err", 64'(bus.resp_err), 64'd0);
      check("rst_resp_rdata", bus.resp_rdata, 64'd0);
      check("rst_req_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      reset = 1'b1;

      for (int w = 0; w < DEPTH; w++) xact(1'b1, 2'd3, 1'b0, 64'(w * 8), {$urandom, $urandom}, 0, rd);

      xact(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, 0, rd);
      xact(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 0, rd);
      check("d_ld_dbl", rd, 64'h1122334455667788);
      xact(1'b1, 2'd0, 1'b0, 64'h13, 64'hAB, 0, rd);
      xact(1'b0, 2'd0, 1'b0, 64'h13, 64'h0, 0, rd);
      check("d_lb", rd, 64'hFFFFFFFFFFFFFFAB);
      xact(1'b0, 2'd0, 1'b1, 64'h13, 64'h0, 0, rd);
      check("d_lbu", rd, 64'h00000000000000AB);
      xact(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 0, rd);
      check("d_ld_merge", rd, 64'h11223344AB667788);

      xact(1'b0, 2'd2, 1'b0, 64'h12, 64'h0, 0, rd);
      check("d_misaligned", rd, 64'h0);
      xact(1'b1, 2'd2, 1'b0, 64'h12, 64'hFFFF_FFFF, 0, rd);
      xact(1'b0, 2'd3, 1'b0, 64'(DEPTH * 8), 64'h0, 0, rd);
      xact(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 0, rd);
      check("d_unchanged", rd, 64'h11223344AB667788);

      xact(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 5, rd);
      check("d_hold", rd, 64'h11223344AB667788);

      xact(1'b1, 2'd1, 1'b0, 64'h20, 64'h1234, 0, rd);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'd1;
      bus.req_addr  = 64'h20;
      bus.req_wdata = 64'hDEAD;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("rstw_in_wait", 64'(state_out), 64'd1);
      reset = 1'b0;
      #1;
      check("rstw_state", 64'(state_out), 64'd0);
      check("rstw_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("rstw_req_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      xact(1'b0, 2'd1, 1'b1, 64'h20, 64'h0, 0, rd);
      check("d_rst_keep", rd, 64'h1234);

      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'd3;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 64'h10;
      bus.resp_ready   = 1'b1;
      check("b2b_start", 64'(state_out), 64'd0);
      for (int k = 1; k <= 3 * (LAT + 2); k++) begin
         @(posedge clk); #1;
         ph     = (k - 1) % (LAT + 2);
         exp_st = (ph < LAT) ? 64'd1 : ((ph == LAT) ? 64'd2 : 64'd0);
         check("b2b_state", 64'(state_out), exp_st);
         check("b2b_valid", 64'(bus.resp_valid), (ph == LAT) ? 64'd1 : 64'd0);
         if (ph == LAT) check("b2b_rdata", bus.resp_rdata, 64'h11223344AB667788);
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b0;

      for (int t = 0; t < 300; t++) begin
         sz = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0)
            addr = 64'($urandom_range(0, DEPTH * 8 + 63));
         else
            addr = 64'($urandom_range(0, DEPTH * 8 - 1)) & ~((64'd1 << sz) - 64'd1);
         if ($urandom_range(0, 31) == 0) addr = {$urandom, $urandom};
         hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
              {$urandom, $urandom}, hold, rd);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
